// File: rtl/iomem_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : iomem_bus_master_if
// Purpose  : Bundles the client request/response port and the iomem bus
//            of iomem_bus_master. Directions in the names are the master's
//            view (_i = into the master, _o = out of the master).
// Ports    : req_*   client request  (valid/ready)
//            rsp_*   client response (one-cycle pulse, no back-pressure)
//            iomem_* bus toward the board-level responder
//            busy_o  master is not idle
// Revision : 1.0  initial release
// ============================================================================
interface iomem_bus_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        req_burst_i;

  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_last_o;
  logic        rsp_err_o;

  logic        iomem_valid_o;
  logic        iomem_ready_i;
  logic [3:0]  iomem_wstrb_o;
  logic [31:0] iomem_addr_o;
  logic [31:0] iomem_wdata_o;
  logic [31:0] iomem_rdata_i;

  logic        busy_o;

  // Bus master (the design itself).
  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, req_burst_i,
    input  iomem_ready_i, iomem_rdata_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_last_o, rsp_err_o,
    output iomem_valid_o, iomem_wstrb_o, iomem_addr_o, iomem_wdata_o,
    output busy_o
  );

  // Environment: client plus responder.
  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, req_burst_i,
    output iomem_ready_i, iomem_rdata_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_last_o, rsp_err_o,
    input  iomem_valid_o, iomem_wstrb_o, iomem_addr_o, iomem_wdata_o,
    input  busy_o
  );
endinterface
`default_nettype wire

// File: rtl/iomem_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : iomem_bus_master
// Purpose  : Initiator on the iomem valid/ready bus. Accepts single-word
//            read/write requests and critical-word-first wrapping line-read
//            bursts, returns one response pulse per beat, and aborts any
//            access whose responder never becomes ready.
// Ports    : clk_i   single clock
//            rst_ni  synchronous active-low reset
//            bus     iomem_bus_master_if.master (req_*, rsp_*, iomem_*, busy_o)
// Params   : LINE_WORDS      words per burst line (power of two, 2..64)
//            TIMEOUT_CYCLES  max valid cycles without ready (>= 2)
// Revision : 1.0  initial release
// ============================================================================
module iomem_bus_master #(
  parameter int LINE_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic           clk_i,
  input  wire logic           rst_ni,
  iomem_bus_master_if.master  bus
);

  localparam int c_OFF  = $clog2(LINE_WORDS * 4);   // byte-offset bits in a line
  localparam int c_IDXW = $clog2(LINE_WORDS);       // word-index bits in a line
  localparam int c_BW   = $clog2(LINE_WORDS) + 1;   // beat counter holds LINE_WORDS
  localparam int c_TW   = $clog2(TIMEOUT_CYCLES);   // holds TIMEOUT_CYCLES-1

  localparam logic [c_BW-1:0] c_BEATS = c_BW'(LINE_WORDS);
  localparam logic [c_TW-1:0] c_TMAX  = c_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic [c_BW-1:0]   r_beats, w_beats;
  logic [c_TW-1:0]   r_tmo,   w_tmo;
  logic [31:0]       r_addr,  w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic [3:0]        r_wstrb, w_wstrb;
  logic              r_valid, w_valid;
  logic              r_rsp_valid, w_rsp_valid;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_last,  w_rsp_last;
  logic              r_rsp_err,   w_rsp_err;

  logic              w_hs;
  logic [c_IDXW-1:0] w_idx_inc;
  logic              w_unused;

  assign w_hs      = r_valid & bus.iomem_ready_i;
  // Only the word index inside the line advances; it wraps naturally.
  assign w_idx_inc = r_addr[c_OFF-1:2] + c_IDXW'(1);
  assign w_unused  = ^bus.req_addr_i[1:0];

  // Next-state and next-register values. Every registered output is
  // computed here and captured by the flop process below.
  always_comb begin
    w_state     = r_state;
    w_beats     = r_beats;
    w_tmo       = r_tmo;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_valid     = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = 32'd0;
    w_rsp_last  = 1'b0;
    w_rsp_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_state = S_ISSUE;
          w_valid = 1'b1;
          w_addr  = {bus.req_addr_i[31:2], 2'b00};
          w_wdata = bus.req_wdata_i;
          w_wstrb = bus.req_wstrb_i;
          w_beats = (bus.req_wstrb_i == 4'd0 && bus.req_burst_i) ? c_BEATS : c_BW'(1);
          w_tmo   = '0;
        end
      end

      S_ISSUE: begin
        w_valid = 1'b1;
        // Handshake has priority over the timeout threshold.
        if (w_hs) begin
          w_valid     = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = (r_wstrb == 4'd0) ? bus.iomem_rdata_i : 32'd0;
          w_beats     = r_beats - c_BW'(1);
          if (r_beats == c_BW'(1)) begin
            w_state    = S_IDLE;
            w_rsp_last = 1'b1;
          end else begin
            w_state = S_GAP;
          end
        end else if (r_tmo == c_TMAX) begin
          // Abort: remaining burst beats are dropped.
          w_state     = S_IDLE;
          w_valid     = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_last  = 1'b1;
        end else begin
          w_tmo = r_tmo + c_TW'(1);
        end
      end

      S_GAP: begin
        w_state = S_ISSUE;
        w_valid = 1'b1;
        w_tmo   = '0;
        w_addr  = {r_addr[31:c_OFF], w_idx_inc, 2'b00};
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_beats     <= '0;
      r_tmo       <= '0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_valid     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_beats     <= w_beats;
      r_tmo       <= w_tmo;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_valid     <= w_valid;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_last  <= w_rsp_last;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign bus.req_ready_o   = (r_state == S_IDLE);
  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_rdata_o   = r_rsp_rdata;
  assign bus.rsp_last_o    = r_rsp_last;
  assign bus.rsp_err_o     = r_rsp_err;
  assign bus.iomem_valid_o = r_valid;
  assign bus.iomem_addr_o  = r_addr;
  assign bus.iomem_wdata_o = r_wdata;
  assign bus.iomem_wstrb_o = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_iomem_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_bus_master
// Purpose  : Self-checking bench for iomem_bus_master: directed cases plus
//            randomized requests against a line/beat/timeout reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_iomem_bus_master;
  localparam int LW = 8;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iomem_bus_master_if bus ();

  iomem_bus_master #(
    .LINE_WORDS     (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;

  // Responder behaviour: delay (in valid cycles before ready) per address.
  // mode 0: zero wait, 1: fixed, 2: hashed random 0..19, 3: one hot word
  // index never ready, other: never ready.
  int          dmode = 0;
  int          dfix  = 0;
  int          dhot  = 0;
  logic [31:0] dsalt = 32'd0;
  logic [31:0] dkey  = 32'd0;
  int          vcnt  = 0;

  function automatic int delay_for(input logic [31:0] a, input int mode, input int fix,
                                   input logic [31:0] salt, input int hot);
    logic [31:0] h;
    case (mode)
      0: return 0;
      1: return fix;
      2: begin
        h = (a ^ salt) * 32'd2654435761;
        return int'(h[31:27]) % 20;
      end
      3: return (int'((a >> 2) & 32'(LW - 1)) == hot) ? 1000 : 0;
      default: return 1000;
    endcase
  endfunction

  assign bus.iomem_ready_i = bus.iomem_valid_o &&
                             (vcnt >= delay_for(bus.iomem_addr_o, dmode, dfix, dsalt, dhot));
  assign bus.iomem_rdata_i = bus.iomem_addr_o ^ dkey;

  always @(posedge clk) begin
    if (!bus.iomem_valid_o || bus.iomem_ready_i) vcnt <= 0;
    else                                         vcnt <= vcnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check1("rst_req_ready", bus.req_ready_o,   1'b1);
    check1("rst_rsp_valid", bus.rsp_valid_o,   1'b0);
    check1("rst_rsp_last",  bus.rsp_last_o,    1'b0);
    check1("rst_rsp_err",   bus.rsp_err_o,     1'b0);
    check1("rst_bus_valid", bus.iomem_valid_o, 1'b0);
    check1("rst_busy",      bus.busy_o,        1'b0);
    check ("rst_rsp_rdata", bus.rsp_rdata_o,   32'd0);
    check ("rst_bus_addr",  bus.iomem_addr_o,  32'd0);
    check ("rst_bus_wdata", bus.iomem_wdata_o, 32'd0);
    check ("rst_bus_wstrb", 32'(bus.iomem_wstrb_o), 32'd0);
  endtask

  // Advance n cycles expecting a quiet, idle master.
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check1("idle_rsp_valid", bus.rsp_valid_o,   1'b0);
      check1("idle_bus_valid", bus.iomem_valid_o, 1'b0);
      check1("idle_req_ready", bus.req_ready_o,   1'b1);
      check1("idle_busy",      bus.busy_o,        1'b0);
    end
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic burst);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_wstrb_i = wstrb;
    bus.req_burst_i = burst;
  endtask

  // Called at a negedge with the master idle. Issues the request and walks
  // every expected bus/response cycle; returns at the final response cycle.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic burst);
    int          beats, idx0, d, wc;
    logic [31:0] base, a;
    logic        rd, err, last;
    rd    = (wstrb == 4'd0);
    beats = (rd && burst) ? LW : 1;
    base  = addr & ~32'(LW * 4 - 1);
    idx0  = int'((addr >> 2) & 32'(LW - 1));
    err   = 1'b0;
    check1("req_ready", bus.req_ready_o, 1'b1);
    drive_req(addr, wdata, wstrb, burst);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < beats && !err; i++) begin
      a    = base | (32'((idx0 + i) % LW) << 2);
      d    = delay_for(a, dmode, dfix, dsalt, dhot);
      wc   = (d + 1 < TO) ? d + 1 : TO;
      err  = (d >= TO);
      last = err || (i == beats - 1);
      for (int c = 0; c < wc; c++) begin
        check1("bus_valid",  bus.iomem_valid_o, 1'b1);
        check ("bus_addr",   bus.iomem_addr_o,  a);
        check ("bus_wdata",  bus.iomem_wdata_o, wdata);
        check ("bus_wstrb",  32'(bus.iomem_wstrb_o), 32'(wstrb));
        check1("rsp_quiet",  bus.rsp_valid_o,   1'b0);
        check1("busy",       bus.busy_o,        1'b1);
        @(negedge clk);
      end
      check1("rsp_valid",   bus.rsp_valid_o,   1'b1);
      check1("rsp_err",     bus.rsp_err_o,     err);
      check1("rsp_last",    bus.rsp_last_o,    last);
      check ("rsp_rdata",   bus.rsp_rdata_o,   (rd && !err) ? (a ^ dkey) : 32'd0);
      check1("bus_gap",     bus.iomem_valid_o, 1'b0);
      check1("ready_after", bus.req_ready_o,   last);
      if (!last) @(negedge clk);
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'd0;
    bus.req_wdata_i = 32'd0;
    bus.req_wstrb_i = 4'd0;
    bus.req_burst_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Single zero-wait read returning 0x1234
    dmode = 0; dkey = 32'h3000_1234;
    run_req(32'h3000_0000, 32'd0, 4'd0, 1'b0);
    idle_cycles(2);

    // Write with a 16-cycle ready delay (ready in the 16th valid cycle)
    dmode = 1; dfix = 15; dkey = 32'd0;
    run_req(32'h4000_0100, 32'hCAFE_F00D, 4'b0011, 1'b0);

    // Wrapping burst, data = address; back-to-back with previous request
    dmode = 0; dkey = 32'd0;
    run_req(32'h4000_0018, 32'd0, 4'd0, 1'b1);
    // Burst flag ignored on a write
    run_req(32'h4000_0203, 32'h1111_2222, 4'b1000, 1'b1);
    idle_cycles(2);

    // Unmapped responder: full timeout
    dmode = 4;
    run_req(32'hE000_0000, 32'd0, 4'd0, 1'b0);
    idle_cycles(2);

    // Ready exactly on the threshold cycle, then one cycle too late
    dmode = 1; dfix = TO - 1; dkey = 32'h0F0F_0F0F;
    run_req(32'h1000_0040, 32'd0, 4'd0, 1'b0);
    dfix = TO;
    run_req(32'h1000_0044, 32'd0, 4'd0, 1'b0);
    idle_cycles(2);

    // Timeout on beat 3 of a burst starting at word 6 (third word is 0)
    dmode = 3; dhot = 0; dkey = 32'd0;
    run_req(32'h4000_0018, 32'd0, 4'd0, 1'b1);
    idle_cycles(4);

    // Reset mid-burst
    dmode = 0;
    drive_req(32'h2000_0010, 32'd0, 4'd0, 1'b1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    idle_cycles(2);
    run_req(32'h2000_0014, 32'd0, 4'd0, 1'b1);

    // Randomized requests
    dmode = 2;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra, rw;
      logic [3:0]  rs;
      logic        rb;
      dsalt = $urandom;
      dkey  = $urandom;
      ra    = $urandom;
      rw    = $urandom;
      rs    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rb    = 1'($urandom_range(0, 1));
      run_req(ra, rw, rs, rb);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
